// File: rtl/wc_pkg.sv
// Constants and state encoding shared by the wc core, its tile feeder and the bench.
package wc_pkg;

    localparam int unsigned W      = 10;
    localparam int unsigned N      = 6;
    localparam int unsigned STRIDE = 2;
    localparam int unsigned DW     = W * N;
    localparam int unsigned NEED_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/wc_tile_feeder.sv
// Assembles overlapping N-sample windows (stride STRIDE) from a sample stream
// into the packed D word consumed by the wc core; trailing partial windows are zero-padded.
module wc_tile_feeder
    import wc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [DW-1:0]       D,
    output logic                out_valid,
    output logic                out_last,
    input  logic                out_ready
);

    state_t              state;
    state_t              state_n;
    logic [NEED_W-1:0]   need;
    logic [NEED_W-1:0]   need_n;
    logic [DW-1:0]       win_n;
    logic                last_n;

    // D is the window register itself; handshake flags are decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            need      <= NEED_W'(N);
            D         <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state     <= state_n;
            need      <= need_n;
            D         <= win_n;
            out_last  <= last_n;
            out_valid <= (state_n == HOLD);
            in_ready  <= (state_n == FILL);
        end
    end

    always_comb begin
        state_n = state;
        need_n  = need;
        win_n   = D;
        last_n  = out_last;
        case (state)
            FILL: begin
                if (in_valid && in_ready) begin
                    win_n  = {D[DW-W-1:0], in_data};
                    need_n = need - NEED_W'(1);
                    if (need == NEED_W'(1)) begin
                        state_n = HOLD;
                        last_n  = in_last;
                    end else if (in_last) begin
                        state_n = PAD;
                    end
                end
            end
            PAD: begin
                win_n  = {D[DW-W-1:0], W'(0)};
                need_n = need - NEED_W'(1);
                if (need == NEED_W'(1)) begin
                    state_n = HOLD;
                    last_n  = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    // a frame's final window leaves no history for the next frame
                    if (out_last) begin
                        win_n  = '0;
                        need_n = NEED_W'(N);
                    end else begin
                        need_n = NEED_W'(STRIDE);
                    end
                    last_n  = 1'b0;
                    state_n = FILL;
                end
            end
            default: state_n = FILL;
        endcase
    end

endmodule

// File: tb/tb_wc_tile_feeder.sv
// Directed bench for wc_tile_feeder: windowing, padding, backpressure and reset.
module tb_wc_tile_feeder;
    import wc_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic signed [W-1:0] in_data;
    logic                in_valid;
    logic                in_last;
    logic                in_ready;
    logic [DW-1:0]       D;
    logic                out_valid;
    logic                out_last;
    logic                out_ready;

    int checks = 0;
    int errors = 0;

    wc_tile_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .D         (D),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] win6(input int e0, input int e1, input int e2,
                                          input int e3, input int e4, input int e5);
        return {W'(e0), W'(e1), W'(e2), W'(e3), W'(e4), W'(e5)};
    endfunction

    // offer one sample at a negedge and hold it until accepted; returns at a negedge
    task automatic send(input int d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = W'(d);
        in_last  = last;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // wait for a window, counting bubble cycles, check it and hand it off
    task automatic recv(input string tag, input logic [DW-1:0] exp_d, input logic exp_last,
                        input int exp_wait);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_wait"}, 64'(n), 64'(exp_wait));
        check({tag, "_d"}, 64'(D), 64'(exp_d));
        check({tag, "_last"}, 64'(out_last), 64'(exp_last));
        check({tag, "_inrdy_hold"}, 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_fall"}, 64'(out_valid), 64'd0);
        check({tag, "_inrdy_rise"}, 64'(in_ready), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        check("rst_inrdy_low", 64'(in_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_d", 64'(D), 64'd0);
        check("rst_inrdy", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [DW-1:0] held;
        logic [DW-1:0] first_ref;
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("init_d", 64'(D), 64'd0);
        check("init_valid", 64'(out_valid), 64'd0);
        check("init_last", 64'(out_last), 64'd0);
        check("init_inrdy", 64'(in_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("init_inrdy_rel", 64'(in_ready), 64'd1);

        // basic windows
        first_ref = 60'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110;
        send(2, 0); send(-10, 0); send(3, 0); send(4, 0); send(-13, 0); send(-18, 0);
        check("basic_w1_literal", 64'(D), 64'(first_ref));
        recv("basic_w1", win6(2, -10, 3, 4, -13, -18), 1'b0, 0);
        send(-19, 0); send(-6, 0);
        recv("basic_w2", win6(3, 4, -13, -18, -19, -6), 1'b0, 0);
        do_reset();

        // trailing window padded by one zero
        for (int i = 1; i <= 6; i++) send(i, 0);
        recv("pad_w1", win6(1, 2, 3, 4, 5, 6), 1'b0, 0);
        send(7, 1);
        recv("pad_w2", win6(3, 4, 5, 6, 7, 0), 1'b1, 1);

        // new frame needs a full N samples; exact end takes no pad
        for (int i = 1; i <= 5; i++) send(i, 0);
        check("exact_no_early", 64'(out_valid), 64'd0);
        check("exact_cleared", 64'(D), 64'(win6(0, 1, 2, 3, 4, 5)));
        send(6, 0);
        recv("exact_w1", win6(1, 2, 3, 4, 5, 6), 1'b0, 0);
        send(7, 0); send(8, 1);
        recv("exact_w2", win6(3, 4, 5, 6, 7, 8), 1'b1, 0);

        // backpressure with a sample offered throughout
        for (int i = 10; i <= 15; i++) send(i, 0);
        held     = D;
        in_valid = 1'b1;
        in_data  = W'(99);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_d_stable", 64'(D), 64'(held));
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_inrdy", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        recv("bp_w1", win6(10, 11, 12, 13, 14, 15), 1'b0, 0);
        send(16, 0); send(17, 1);
        recv("bp_w2", win6(12, 13, 14, 15, 16, 17), 1'b1, 0);

        // single-sample frame
        send(5, 1);
        recv("short", win6(5, 0, 0, 0, 0, 0), 1'b1, 5);

        // reset during fill discards the partial window
        for (int i = 1; i <= 4; i++) send(i, 0);
        do_reset();
        for (int i = 21; i <= 25; i++) send(i, 0);
        check("rstfill_no_early", 64'(out_valid), 64'd0);
        send(26, 0);
        recv("rstfill_w", win6(21, 22, 23, 24, 25, 26), 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got 0 exp 1");
        $fatal(1, "timeout");
    end

endmodule
